shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-006 a  input  32  operand to be shifted; captured on accepted start.
REQ-007 b  input  32  shift amount, unsigned; captured on accepted start.
REQ-008 busy  output  1  high while a request is in progress (SHIFT or DONE state).
REQ-009 done  output  1  single-cycle pulse; s and err are valid in that cycle.
REQ-010 s  output  32  result register; held from done until the next accepted start.
REQ-011 err  output  1  set with done when op was illegal; held like s.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a into s, op, and a 5-bit count; this is an "accepted start".
REQ-014 The captured count SHALL be b[4:0] when b<32, and SHALL otherwise be handled by REQ-019.
REQ-015 On an accepted start, the next state SHALL be SHIFT when count>0, and DONE when count=0 or op=11.
REQ-016 In SHIFT, each edge SHALL shift s by exactly one bit and decrement count.
- SLL: zero fill from the left shift direction, i.e. s <= {s[30:0],0}.
- SRL: s <= {0,s[31:1]}.
- SRA: s <= {s[31],s[31:1]}.
REQ-017 SHIFT SHALL go to DONE on the edge where count goes 1->0.
REQ-018 Latency: done SHALL assert exactly n+1 cycles after the accepted-start edge, where n is the effective count; n=0 gives done in the next cycle.
REQ-019 When b>=32, the block SHALL go directly to DONE with the following result:
- SLL and SRL: s=0.
- SRA: s = 32 copies of a[31].
REQ-020 For op=11, the block SHALL set s=a and err=1; for every legal op, err SHALL be 0 at done.
REQ-021 DONE SHALL last one cycle, assert done=1 and busy=1, and return to IDLE unconditionally.
REQ-022 start SHALL be ignored while busy=1; a start coincident with done SHALL be dropped.
REQ-023 A start in IDLE the cycle after done SHALL be accepted; back-to-back throughput is n+2 cycles per request.
REQ-024 a, b and op SHALL be ignored outside an accepted start; input changes during SHIFT SHALL NOT affect the result.
REQ-025 s SHALL be updated only on accepted start, in SHIFT, or by rst.
REQ-026 busy SHALL be 0 in IDLE and SHALL be a registered state decode with no combinational path from start.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set state=IDLE, s=0, err=0, count=0, done=0 and busy=0.
REQ-028 rst SHALL take priority over start and over any in-progress SHIFT or DONE state.
REQ-029 A request aborted by rst SHALL produce no done pulse.
REQ-030 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-031 Scenario: start with op=00, a=0x0000_0001, b=4 -> busy high for 5 cycles; done in cycle 5 after accept with s=0x0000_0010 and err=0.
REQ-032 Scenario: op=10, a=0x8000_0000, b=31 -> done 32 cycles after accept with s=0xFFFF_FFFF; op=01 with the same a and b -> s=0x0000_0001.
REQ-033 Scenario: op=10, a=0x8000_0000, b=40 -> done 1 cycle after accept with s=0xFFFF_FFFF; op=00, a=0xFFFF_FFFF, b=32 -> s=0.
REQ-034 Scenario: op=11, a=0x1234_5678, b=3 -> done 1 cycle after accept with s=0x1234_5678 and err=1; the next legal request clears err.
REQ-035 Scenario: start held high continuously with a, b and op changed mid-SHIFT -> result reflects only the captured values, and the next request is accepted only in the cycle after done.
REQ-036 Scenario: rst asserted during SHIFT of b=20 -> next cycle state=IDLE, s=0 and busy=0, with no done pulse; a new start on the following edge completes normally.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle for shift_sequencer
//   start : request strobe, sampled only while the sequencer is idle
//   op    : 00 SLL, 01 SRL, 10 SRA, 11 illegal
//   a     : operand captured on an accepted start
//   b     : unsigned shift amount captured on an accepted start
//   busy  : request in progress
//   done  : one-cycle completion pulse, s/err valid with it
//   s     : result, held until the next accepted start
//   err   : illegal-op flag, held like s
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        err;

  modport master (output start, op, a, b, input busy, done, s, err);
  modport slave  (input start, op, a, b, output busy, done, s, err);
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - bit-serial 32-bit shifter, one bit per clock
//   clk : system clock, all state updates on its rising edge
//   rst : synchronous active-high reset
//   bus : shift_sequencer_if.slave (start/op/a/b in, busy/done/s/err out)
module shift_sequencer (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        err_q, err_d;

  // Any amount of 32 or more collapses to a single fill result.
  logic b_big;
  logic skip_shift;
  assign b_big      = |bus.b[31:5];
  assign skip_shift = (bus.op == OP_ILL) || b_big || (bus.b[4:0] == 5'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = skip_shift ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == 5'd1) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state only, so start never reaches busy.
  always_comb begin
    bus.busy = (state_q != ST_IDLE);
    bus.done = (state_q == ST_DONE);
    bus.s    = s_q;
    bus.err  = err_q;
  end

  // Datapath: capture on accepted start, one bit per cycle in SHIFT
  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          err_d = (bus.op == OP_ILL);
          if (bus.op == OP_ILL) begin
            s_d   = bus.a;
            cnt_d = 5'd0;
          end else if (b_big) begin
            s_d   = (bus.op == OP_SLL || bus.op == OP_SRL) ? 32'd0 : {32{bus.a[31]}};
            cnt_d = 5'd0;
          end else begin
            s_d   = bus.a;
            cnt_d = bus.b[4:0];
          end
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - 5'd1;
        case (op_q)
          OP_SLL:  s_d = {s_q[30:0], 1'b0};
          OP_SRL:  s_d = {1'b0, s_q[31:1]};
          default: s_d = {s_q[31], s_q[31:1]};
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 32'd0;
      cnt_q <= 5'd0;
      op_q  <= 2'd0;
      err_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      err_q <= err_d;
    end
  end

endmodule
